instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: ADDR_W, 32, width of PC and instruction-memory address.
REQ-002 Parameter: DATA_W, 32, instruction width.
REQ-003 Parameter: HALT_OPC, 6'b111111, opcode in instr[31:26] identifying HALT.
REQ-004 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: pc_in  in  ADDR_W  current PC from the PC register.
REQ-007 Port: pc_stall  out  1  freeze request to the PC register.
REQ-008 Port: halt  out  1  sticky halt to the PC register.
REQ-009 Port: flush  in  1  branch/jump redirect; discard all fetched-but-undelivered work.
REQ-010 Port: imem_req  out  1  read request to instruction memory.
REQ-011 Port: imem_addr  out  ADDR_W  read address, equal to pc_in.
REQ-012 Port: imem_gnt  in  1  request accepted this cycle.
REQ-013 Port: imem_rvalid  in  1  read data valid, one per granted request, in order.
REQ-014 Port: imem_rdata  in  DATA_W  read data.
REQ-015 Port: id_valid  out  1  instruction available to decode.
REQ-016 Port: id_ready  in  1  decode accepts instruction.
REQ-017 Port: id_instr  out  DATA_W  instruction at FIFO head.
REQ-018 Port: id_pc  out  ADDR_W  PC of instruction at FIFO head.

Function
REQ-019 2-entry FIFO of {pc, instr}; at most one outstanding memory request.
REQ-020 FSM states: IDLE (no request outstanding), WAIT (granted, awaiting rvalid), HALTED.
REQ-021 imem_req=1 only in IDLE when flush=0, halt_pending=0, and fifo_count+outstanding<2.
REQ-022 IDLE->WAIT on imem_req&imem_gnt; PC of the granted request is latched as req_pc.
REQ-023 WAIT->IDLE on imem_rvalid; {req_pc, imem_rdata} pushed unless drop flag set; drop flag then cleared.
REQ-024 rvalid and next request in the same cycle not allowed; new request earliest the cycle after rvalid.
REQ-025 pc_stall = 0 when flush=1 or (imem_req & imem_gnt); otherwise 1.
REQ-026 Latency: grant cycle N, rvalid cycle M>=N+1, id_valid=1 from cycle M+1 when FIFO was empty.
REQ-027 id_valid = fifo_count!=0; pop on id_valid&id_ready.
REQ-028 Simultaneous push and pop: count unchanged, order preserved; push when full is impossible by REQ-021.
REQ-029 flush: FIFO emptied same edge; if in WAIT, drop flag set so the pending response is discarded; halt_pending cleared; no push or pop that cycle.
REQ-030 halt_pending set when a pushed instr has instr[31:26]==HALT_OPC; blocks further requests.
REQ-031 halt set on the edge where a HALT instruction is popped (id_valid&id_ready); FSM->HALTED; sticky until rst.
REQ-032 HALTED: imem_req=0, pc_stall=1, flush ignored, FIFO may still drain nothing further.

Reset
REQ-033 rst asserted: FSM=IDLE, FIFO empty, drop=0, halt_pending=0, halt=0, id_valid=0, imem_req=0, pc_stall=1 while rst high.
REQ-034 rst mid-WAIT: outstanding response after rst release is ignored only if it arrives before the first new request; memory is reset alongside, so no stale rvalid is expected.

Structure
REQ-035 Shared package holds HALT_OPC, opcode field bounds [31:26], and the fetch FSM state encoding.
REQ-036 One sub-module: fetch_fifo (2-entry, synchronous push/pop/clear, count output).

Verification
REQ-037 Zero-wait memory (gnt=1, rvalid next cycle), id_ready=1, pc 0..3 -> instrs delivered in order, id_pc 0,1,2,3, one per 2 cycles.
REQ-038 id_ready=0 for 6 cycles -> exactly 2 entries buffered, imem_req=0, pc_stall=1; release -> both delivered in order, no loss.
REQ-039 flush in WAIT at pc=5 -> response for pc 5 discarded, FIFO empty, pc_stall=0 that cycle, next request uses redirected pc_in=20.
REQ-040 HALT (instr 0xFC000000) at pc=7 -> no request after it; halt=1 the edge after its pop; pc_stall=1 thereafter until rst.
REQ-041 rst asserted mid-operation with 2 entries buffered -> id_valid=0, halt=0, FSM IDLE immediately (asynchronous); fetch resumes from pc_in=0 after release.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch unit: HALT opcode, opcode field
// bounds and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam logic [5:0] OPC_HALT = 6'b111111;
  localparam int         OPC_HI   = 31;
  localparam int         OPC_LO   = 26;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE   = 2'd0;
  localparam fetch_state_t ST_WAIT   = 2'd1;
  localparam fetch_state_t ST_HALTED = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched {pc, instr} words with synchronous push, pop and
// clear; clear wins over any push or pop in the same cycle.
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read, 2-deep {pc, instr} buffer to
// decode, flush redirect with response drop, and a sticky HALT on its delivery.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter logic [5:0] HALT_OPC = OPC_HALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_stall,
  output logic              halt,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc
);

  fetch_state_t              state;
  logic                      drop;
  logic                      halt_pending;
  logic [ADDR_W-1:0]         req_pc;
  logic [1:0]                fifo_count;
  logic [ADDR_W+DATA_W-1:0]  fifo_dout;
  logic [2:0]                inflight;
  logic                      outstanding;
  logic                      flush_act;
  logic                      grant;
  logic                      resp;
  logic                      push;
  logic                      pop;
  logic                      push_is_halt;
  logic                      head_is_halt;

  // Once halted the unit no longer reacts to redirects.
  assign flush_act    = flush && (state != ST_HALTED);
  assign outstanding  = (state == ST_WAIT);
  assign inflight     = {1'b0, fifo_count} + {2'b00, outstanding};

  assign imem_addr    = pc_in;
  assign imem_req     = !rst && (state == ST_IDLE) && !flush && !halt_pending
                        && (inflight < 3'd2);
  assign grant        = imem_req && imem_gnt;
  assign pc_stall     = rst || (state == ST_HALTED) || !(flush || grant);

  assign resp         = outstanding && imem_rvalid;
  assign push         = resp && !drop && !flush_act;
  assign pop          = id_valid && id_ready && !flush_act;

  assign push_is_halt = (imem_rdata[OPC_HI:OPC_LO] == HALT_OPC);
  assign head_is_halt = (id_instr[OPC_HI:OPC_LO] == HALT_OPC);

  assign id_valid     = (fifo_count != 2'd0);
  assign id_pc        = fifo_dout[ADDR_W+DATA_W-1:DATA_W];
  assign id_instr     = fifo_dout[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      drop         <= 1'b0;
      halt_pending <= 1'b0;
      halt         <= 1'b0;
      req_pc       <= '0;
    end else begin
      if (pop && head_is_halt) begin
        halt  <= 1'b1;
        state <= ST_HALTED;
      end else begin
        case (state)
          ST_IDLE: begin
            if (grant) begin
              state  <= ST_WAIT;
              req_pc <= pc_in;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid) state <= ST_IDLE;
          end
          ST_HALTED: state <= ST_HALTED;
          default:   state <= ST_IDLE;
        endcase
      end

      // A response landing in the flush cycle is itself the one being dropped.
      if (resp)
        drop <= 1'b0;
      else if (flush_act && outstanding)
        drop <= 1'b1;

      if (flush_act)
        halt_pending <= 1'b0;
      else if (push && push_is_halt)
        halt_pending <= 1'b1;
    end
  end

  fetch_fifo #(
    .W(ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush_act),
    .din   ({req_pc, imem_rdata}),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a PC register and a fixed-latency memory are
// modelled inline, and every expected value below is worked out by hand.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pc_stall;
  logic        halt;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = '0;
  logic [31:0] flush_pc = '0;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_stall    (pc_stall),
    .halt        (halt),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] instr_at(input logic [31:0] addr);
    if (addr == 32'd7) return 32'hFC00_0000;
    return 32'h1000_0000 | addr;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample pre-edge handshakes, then update PC register and memory.
  task automatic tick();
    logic        g;
    logic        fl;
    logic        st;
    logic [31:0] a;
    #1;
    g  = imem_req & imem_gnt;
    fl = flush;
    st = pc_stall;
    a  = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (rst) begin
      pc_in    = '0;
      resp_cnt = 0;
    end else begin
      if (fl)       pc_in = flush_pc;
      else if (!st) pc_in = pc_in + 32'd1;
      if (g) begin
        resp_cnt  = mem_lat;
        resp_addr = a;
      end
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instr_at(resp_addr);
        end
      end
    end
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_halt",     {31'd0, halt},     32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc_stall", {31'd0, pc_stall}, 32'd1);
    rst = 1'b0;
    #1;

    // Zero-wait memory, pc 0..3, one delivery every 2 cycles
    chk("z_req0",   {31'd0, imem_req}, 32'd1);
    chk("z_addr0",  imem_addr,         32'd0);
    chk("z_stall0", {31'd0, pc_stall}, 32'd0);
    tick();
    chk("z_wait_req",   {31'd0, imem_req}, 32'd0);
    chk("z_wait_stall", {31'd0, pc_stall}, 32'd1);
    chk("z_wait_valid", {31'd0, id_valid}, 32'd0);
    tick();
    chk("z_valid0", {31'd0, id_valid}, 32'd1);
    chk("z_pc0",    id_pc,             32'd0);
    chk("z_instr0", id_instr,          32'h1000_0000);
    chk("z_addr1",  imem_addr,         32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("z_gap_valid", {31'd0, id_valid}, 32'd0);
      tick();
      chk("z_valid", {31'd0, id_valid}, 32'd1);
      chk("z_pc",    id_pc,             k);
      chk("z_instr", id_instr,          32'h1000_0000 | k);
    end

    // Flush while waiting on pc 5, redirect to 20
    tick();
    mem_lat = 3;
    tick();
    chk("f_pc4",   id_pc,     32'd4);
    chk("f_addr5", imem_addr, 32'd5);
    id_ready = 1'b0;
    tick();
    chk("f_held_pc4", id_pc, 32'd4);
    flush    = 1'b1;
    flush_pc = 32'd20;
    #1;
    chk("f_stall", {31'd0, pc_stall}, 32'd0);
    chk("f_req",   {31'd0, imem_req}, 32'd0);
    tick();
    flush    = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("f_empty",      {31'd0, id_valid}, 32'd0);
    chk("f_wait_stall", {31'd0, pc_stall}, 32'd1);
    tick();
    chk("f_drop_rvalid", {31'd0, imem_rvalid}, 32'd1);
    tick();
    chk("f_dropped", {31'd0, id_valid}, 32'd0);
    chk("f_req20",   {31'd0, imem_req}, 32'd1);
    chk("f_addr20",  imem_addr,         32'd20);
    mem_lat = 1;

    // Decode back-pressure for 6 cycles
    id_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c >= 3) begin
        chk("bp_req",   {31'd0, imem_req}, 32'd0);
        chk("bp_stall", {31'd0, pc_stall}, 32'd1);
        chk("bp_pc20",  id_pc,             32'd20);
      end
    end
    id_ready = 1'b1;
    #1;
    chk("bp_full_req", {31'd0, imem_req}, 32'd0);
    chk("bp_head20",   id_pc,             32'd20);
    tick();
    chk("bp_valid21", {31'd0, id_valid}, 32'd1);
    chk("bp_head21",  id_pc,             32'd21);
    chk("bp_instr21", id_instr,          32'h1000_0015);
    chk("bp_addr22",  imem_addr,         32'd22);

    // Asynchronous reset with two entries buffered
    id_ready = 1'b0;
    tick();
    tick();
    chk("r_full_head", id_pc,             32'd21);
    chk("r_full_req",  {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("r_valid", {31'd0, id_valid}, 32'd0);
    chk("r_halt",  {31'd0, halt},     32'd0);
    chk("r_req",   {31'd0, imem_req}, 32'd0);
    chk("r_stall", {31'd0, pc_stall}, 32'd1);
    tick();
    rst      = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("r_resume_req",  {31'd0, imem_req}, 32'd1);
    chk("r_resume_addr", imem_addr,         32'd0);
    tick();
    tick();
    chk("r_resume_valid", {31'd0, id_valid}, 32'd1);
    chk("r_resume_pc",    id_pc,             32'd0);

    // Redirect to 7 and fetch HALT
    flush    = 1'b1;
    flush_pc = 32'd7;
    tick();
    flush = 1'b0;
    #1;
    chk("h_empty", {31'd0, id_valid}, 32'd0);
    chk("h_addr7", imem_addr,         32'd7);
    chk("h_req7",  {31'd0, imem_req}, 32'd1);
    tick();
    tick();
    chk("h_valid",   {31'd0, id_valid}, 32'd1);
    chk("h_pc7",     id_pc,             32'd7);
    chk("h_instr",   id_instr,          32'hFC00_0000);
    chk("h_no_req",  {31'd0, imem_req}, 32'd0);
    chk("h_stall",   {31'd0, pc_stall}, 32'd1);
    chk("h_pre",     {31'd0, halt},     32'd0);
    tick();
    chk("h_halt",     {31'd0, halt},     32'd1);
    chk("h_drained",  {31'd0, id_valid}, 32'd0);
    chk("h_req_off",  {31'd0, imem_req}, 32'd0);
    flush    = 1'b1;
    flush_pc = 32'd40;
    #1;
    chk("h_flush_stall", {31'd0, pc_stall}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("h_sticky", {31'd0, halt},     32'd1);
      chk("h_req",    {31'd0, imem_req}, 32'd0);
      chk("h_stall2", {31'd0, pc_stall}, 32'd1);
    end
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
